apb_rr_master: RTL and testbench

Round-robin APB master that shares one APB bus between `NREQ` local requesters. Each requester posts a single read or write. The block:
- arbitrates between them,
- drives the APB SETUP and ACCESS phases toward the slave,
- waits for `PREADY`,
- returns read data and error status to the winner.

It sits between the internal requesters (CPU port, DMA, debug) and the APB slave bus.

---
 rtl/apb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 54 +++++
 rtl/apb_rr_master.sv | 158 +++++++++++++++
 tb/tb_apb_rr_master.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default sizing for the round-robin APB master.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int DEF_NREQ    = 2;
    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last grant,
// wrapping around, and remembers the winner when the grant is taken.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_valid
);

    logic [IW-1:0]   last;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] rotated;
    int              pick;

    // Pointer to the most recent winner; reset value makes requester 0 win first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= IW'(NREQ - 1);
        end else if (advance && grant_valid) begin
            last <= grant_idx;
        end
    end

    // Rotate eligible requests so bit 0 is last+1, take the first set bit, map back.
    always_comb begin
        eligible    = req & mask;
        rotated     = NREQ'({eligible, eligible} >> (int'(last) + 1));
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pick        = 0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                pick        = int'(last) + 1 + j;
                grant_valid = 1'b1;
            end
        end
        if (pick >= NREQ) begin
            pick = pick - NREQ;
        end
        if (grant_valid) begin
            grant_idx = IW'(pick);
            grant     = NREQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by several requesters: round-robin grant, SETUP/ACCESS
// sequencing, wait states with optional timeout, one-cycle completion pulse.
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [NREQ-1:0]  i_req,
    input  logic [NREQ-1:0]  i_wr,
    input  logic [NREQ*AW-1:0] i_addr,
    input  logic [NREQ*DW-1:0] i_wdata,
    output logic [NREQ-1:0]  o_done,
    output logic [DW-1:0]    o_rdata,
    output logic             o_err,
    output logic [AW-1:0]    PADDR,
    output logic             PWRITE,
    output logic [DW-1:0]    PWDATA,
    output logic             PSELx,
    output logic             PENABLE,
    input  logic [DW-1:0]    PRDATA,
    input  logic             PREADY,
    input  logic             PSLVERR
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_valid;
    logic            advance;
    logic            finish_ok;
    logic            finish_to;
    logic [NREQ-1:0] cur_grant;
    logic [TW-1:0]   tcnt;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_wr;

    // The requester that just completed is masked out for its done cycle.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk        (i_clk),
        .reset_n    (i_reset_n),
        .req        (i_req),
        .mask       (~o_done),
        .advance    (advance),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    // State register; async reset drops PSELx/PENABLE immediately.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bus strobes and completion conditions.
    always_comb begin
        state_d   = state_q;
        PSELx     = 1'b0;
        PENABLE   = 1'b0;
        advance   = 1'b0;
        finish_ok = 1'b0;
        finish_to = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    advance = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                PSELx   = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                PSELx   = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    finish_ok = 1'b1;
                    state_d   = IDLE;
                end else if ((TIMEOUT > 0) && (tcnt == TLIM)) begin
                    finish_to = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the winning requester's address, data and direction.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_addr  = i_addr[i*AW +: AW];
                sel_wdata = i_wdata[i*DW +: DW];
                sel_wr    = i_wr[i];
            end
        end
    end

    // Wait-state counter: cleared in SETUP, counts ACCESS cycles without PREADY, saturates.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tcnt <= '0;
        end else if (state_q == SETUP) begin
            tcnt <= '0;
        end else if ((state_q == ACCESS) && !PREADY && (tcnt != '1)) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Latched bus fields on grant; completion pulse and response on finish.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            cur_grant <= '0;
            o_done    <= '0;
            o_rdata   <= '0;
            o_err     <= 1'b0;
        end else begin
            o_done  <= '0;
            o_rdata <= '0;
            o_err   <= 1'b0;
            if (advance) begin
                PADDR     <= sel_addr;
                PWRITE    <= sel_wr;
                PWDATA    <= sel_wdata;
                cur_grant <= grant;
            end
            if (finish_ok) begin
                o_done  <= cur_grant;
                o_rdata <= PWRITE ? '0 : PRDATA;
                o_err   <= PSLVERR;
            end else if (finish_to) begin
                o_done <= cur_grant;
                o_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed self-checking bench for apb_rr_master with three requesters and a short timeout.
module tb_apb_rr_master;

    localparam int NREQ    = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    logic              clk;
    logic              reset_n;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   wr;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   done;
    logic [DW-1:0]     rdata;
    logic              err;
    logic [AW-1:0]     paddr;
    logic              pwrite;
    logic [DW-1:0]     pwdata;
    logic              psel;
    logic              penable;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;

    int total = 0;
    int bad   = 0;

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk    (clk),
        .i_reset_n(reset_n),
        .i_req    (req),
        .i_wr     (wr),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .o_done   (done),
        .o_rdata  (rdata),
        .o_err    (err),
        .PADDR    (paddr),
        .PWRITE   (pwrite),
        .PWDATA   (pwdata),
        .PSELx    (psel),
        .PENABLE  (penable),
        .PRDATA   (prdata),
        .PREADY   (pready),
        .PSLVERR  (pslverr)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Directed sequence; inputs change and outputs are sampled on the falling edge.
    initial begin
        logic [2:0]  exp_done;
        logic [31:0] exp_addr;

        reset_n = 1'b0;
        req     = '0;
        wr      = '0;
        addr    = '0;
        wdata   = '0;
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        repeat (2) step();

        check_output("rst_psel",    32'(psel),    32'h0);
        check_output("rst_penable", 32'(penable), 32'h0);
        check_output("rst_paddr",   paddr,        32'h0);
        check_output("rst_pwrite",  32'(pwrite),  32'h0);
        check_output("rst_pwdata",  pwdata,       32'h0);
        check_output("rst_done",    32'(done),    32'h0);
        check_output("rst_rdata",   rdata,        32'h0);
        check_output("rst_err",     32'(err),     32'h0);

        // Single write from requester 0, zero wait states.
        reset_n        = 1'b1;
        req            = 3'b001;
        wr             = 3'b001;
        addr[31:0]     = 32'h10;
        wdata[31:0]    = 32'hDEADBEEF;
        pready         = 1'b1;
        step();
        check_output("wr_setup_psel",    32'(psel),    32'h1);
        check_output("wr_setup_penable", 32'(penable), 32'h0);
        check_output("wr_setup_paddr",   paddr,        32'h10);
        check_output("wr_setup_pwrite",  32'(pwrite),  32'h1);
        check_output("wr_setup_pwdata",  pwdata,       32'hDEADBEEF);
        check_output("wr_setup_done",    32'(done),    32'h0);
        step();
        check_output("wr_access_psel",    32'(psel),    32'h1);
        check_output("wr_access_penable", 32'(penable), 32'h1);
        step();
        check_output("wr_done",      32'(done), 32'h1);
        check_output("wr_err",       32'(err),  32'h0);
        check_output("wr_rdata",     rdata,     32'h0);
        check_output("wr_done_psel", 32'(psel), 32'h0);
        req = 3'b000;
        step();
        check_output("wr_after_done", 32'(done), 32'h0);
        check_output("wr_after_psel", 32'(psel), 32'h0);

        // Read from requester 1 with two wait states; PSLVERR without PREADY is ignored.
        req          = 3'b010;
        wr           = 3'b000;
        addr[63:32]  = 32'h20;
        pready       = 1'b0;
        pslverr      = 1'b1;
        prdata       = 32'hFFFF0000;
        step();
        check_output("rd_setup_paddr",   paddr,        32'h20);
        check_output("rd_setup_pwrite",  32'(pwrite),  32'h0);
        check_output("rd_setup_penable", 32'(penable), 32'h0);
        step();
        check_output("rd_acc1_penable", 32'(penable), 32'h1);
        check_output("rd_acc1_done",    32'(done),    32'h0);
        step();
        check_output("rd_acc2_paddr", paddr,      32'h20);
        check_output("rd_acc2_done",  32'(done),  32'h0);
        step();
        check_output("rd_acc3_penable", 32'(penable), 32'h1);
        check_output("rd_acc3_paddr",   paddr,        32'h20);
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'h12345678;
        step();
        check_output("rd_done",  32'(done), 32'h2);
        check_output("rd_rdata", rdata,     32'h12345678);
        check_output("rd_err",   32'(err),  32'h0);
        check_output("rd_psel",  32'(psel), 32'h0);
        req    = 3'b000;
        pready = 1'b0;

        // Write from requester 2 answered with PSLVERR.
        req           = 3'b100;
        wr            = 3'b100;
        addr[95:64]   = 32'h30;
        wdata[95:64]  = 32'hCAFEF00D;
        pready        = 1'b1;
        pslverr       = 1'b1;
        prdata        = 32'h55;
        step();
        check_output("se_setup_pwdata", pwdata, 32'hCAFEF00D);
        check_output("se_setup_paddr",  paddr,  32'h30);
        step();
        step();
        check_output("se_done",  32'(done), 32'h4);
        check_output("se_err",   32'(err),  32'h1);
        check_output("se_rdata", rdata,     32'h0);
        req     = 3'b000;
        pslverr = 1'b0;
        pready  = 1'b0;

        // Timeout: requester 0 read, PREADY stuck low for four ACCESS cycles.
        req         = 3'b001;
        wr          = 3'b000;
        addr[31:0]  = 32'h40;
        prdata      = 32'hBAD0BAD0;
        step();
        check_output("to_setup_psel",    32'(psel),    32'h1);
        check_output("to_setup_penable", 32'(penable), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_output("to_access_penable", 32'(penable), 32'h1);
            check_output("to_access_done",    32'(done),    32'h0);
        end
        step();
        check_output("to_done",  32'(done), 32'h1);
        check_output("to_err",   32'(err),  32'h1);
        check_output("to_rdata", rdata,     32'h0);
        check_output("to_psel",  32'(psel), 32'h0);
        req = 3'b000;

        // Asynchronous reset in the middle of ACCESS.
        req          = 3'b010;
        addr[63:32]  = 32'h24;
        step();
        step();
        check_output("rs_access_penable", 32'(penable), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("rs_psel_async",    32'(psel),    32'h0);
        check_output("rs_penable_async", 32'(penable), 32'h0);
        check_output("rs_done_async",    32'(done),    32'h0);
        req = 3'b000;
        step();
        check_output("rs_done_held", 32'(done), 32'h0);
        check_output("rs_psel_held", 32'(psel), 32'h0);

        // Contention after reset: all three held, grant order 0,1,2 repeating.
        reset_n     = 1'b1;
        req         = 3'b111;
        wr          = 3'b000;
        addr[31:0]  = 32'h100;
        addr[63:32] = 32'h104;
        addr[95:64] = 32'h108;
        pready      = 1'b1;
        prdata      = 32'hA5A50000;
        for (int n = 0; n < 9; n++) begin
            exp_done = 3'b001 << (n % 3);
            exp_addr = 32'h100 + 32'(4 * (n % 3));
            step();
            check_output("rr_setup_paddr", paddr, exp_addr);
            step();
            step();
            if (n == 8) begin
                req = 3'b000;
            end
            check_output("rr_done",  32'(done), 32'(exp_done));
            check_output("rr_rdata", rdata,     32'hA5A50000);
        end
        step();
        check_output("rr_idle_psel", 32'(psel), 32'h0);
        check_output("rr_idle_done", 32'(done), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
